// File: rtl/nibble_serial_addsub_pkg.sv
// Shared ALU definitions: nibble width, saturation limits, FSM encoding and
// the add/subtract select encoding used by the ALU decoder.
package nibble_serial_addsub_pkg;

  localparam int NIB_W = 4;

  // Saturation limits for the default 16-bit datapath.
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/nibble_serial_addsub_nibble.sv
// One 4-bit ripple slice. Exposes the carry into bit 3 as well as the carry
// out so the caller can derive signed overflow on the top nibble.
module nibble_addsub
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             c3,
  output logic             cout
);

  logic [3:0] lo;
  logic [1:0] hi;

  // Split the add at bit 3 so the carry into the sign position is visible.
  always_comb begin
    lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    c3   = lo[3];
    hi   = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
    s    = {hi[0], lo[2:0]};
    cout = hi[1];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle signed add/subtract: one nibble per cycle, LSB first, with the
// inter-nibble carry held in a register. Optional saturation on overflow.
// WIDTH must be a multiple of 4; STEPS is derived and must not be overridden.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEPS = WIDTH / NIB_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // holds b, already inverted for subtract
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               sat_en_q, sat_en_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_v_q, flag_v_d;
  logic               flag_n_q, flag_n_d;

  logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
  logic               nib_c3, nib_cout;
  logic               ovf;
  logic [WIDTH-1:0]   final_res;

  // Clamp to the signed limits; the direction comes from the wrapped sign bit
  // (MSB set after overflow means the true result was positive).
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic             v,
                                                input logic             en);
    if (en && v) begin
      if (raw[WIDTH-1]) return {1'b0, {(WIDTH-1){1'b1}}};
      else              return {1'b1, {(WIDTH-1){1'b0}}};
    end
    return raw;
  endfunction

  // Step-indexed operand mux feeding the single shared slice.
  always_comb begin
    nib_a = a_q[step_q*NIB_W +: NIB_W];
    nib_b = b_q[step_q*NIB_W +: NIB_W];
  end

  nibble_addsub u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .c3   (nib_c3),
    .cout (nib_cout)
  );

  // Next-state, datapath update and DONE-entry result/flag load.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    step_d    = step_q;
    sat_en_d  = sat_en_q;
    result_d  = result_q;
    flag_z_d  = flag_z_q;
    flag_v_d  = flag_v_q;
    flag_n_d  = flag_n_q;
    ovf       = nib_c3 ^ nib_cout;
    final_res = acc_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = a;
          b_d      = b ^ {WIDTH{sub == OP_SUB}};
          carry_d  = (sub == OP_SUB);
          step_d   = '0;
          sat_en_d = sat_en;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[step_q*NIB_W +: NIB_W] = nib_s;
        carry_d = nib_cout;
        step_d  = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          // Top nibble: overflow from carry-in vs carry-out of the sign bit.
          state_d   = ST_DONE;
          step_d    = '0;
          final_res = saturate(acc_d, ovf, sat_en_q);
          result_d  = final_res;
          flag_z_d  = (final_res == '0);
          flag_n_d  = final_res[WIDTH-1];
          flag_v_d  = ovf;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any partial op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      step_q   <= '0;
      sat_en_q <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      step_q   <= step_d;
      sat_en_q <= sat_en_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_v = flag_v_q;
  assign flag_n = flag_n_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench: expected responses are queued at issue, a monitor pops
// and compares on every done pulse (including latency).
module tb_nibble_serial_addsub;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, start, sub, sat_en;
  logic [W-1:0]  a, b;
  logic          busy, done, flag_z, flag_v, flag_n;
  logic [W-1:0]  result;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .sat_en(sat_en),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    bit z, v, n;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: exact signed integer arithmetic, then wrap or clamp.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input bit isub, input bit isat, input int c);
    exp_t e;
    int sa, sb, r;
    sa = $signed(ia);
    sb = $signed(ib);
    r  = isub ? sa - sb : sa + sb;
    e.v = (r > 32767) || (r < -32768);
    if (e.v && isat) e.res = (r > 0) ? 16'h7FFF : 16'h8000;
    else             e.res = r[15:0];
    e.z = (e.res == 16'h0000);
    e.n = e.res[15];
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d result %h", cyc, result);
      end else begin
        mon_e = q.pop_front();
        chk("result",  {16'h0, result}, {16'h0, mon_e.res});
        chk("flag_z",  {31'h0, flag_z}, {31'h0, mon_e.z});
        chk("flag_v",  {31'h0, flag_v}, {31'h0, mon_e.v});
        chk("flag_n",  {31'h0, flag_n}, {31'h0, mon_e.n});
        chk("latency", cyc, mon_e.cyc + 5);
        chk("busy_in_done", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit isub, input bit isat, input bit expect_accept);
    start  = 1'b1;
    a      = ia;
    b      = ib;
    sub    = isub;
    sat_en = isat;
    if (expect_accept) q.push_back(model(ia, ib, isub, isat, cyc));
  endtask

  task automatic release_start;
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    sub    = 1'($urandom);
    sat_en = 1'($urandom);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no done expected done within 20 cycles", nm);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit isub, input bit isat, input string nm);
    @(negedge clk);
    drive(ia, ib, isub, isat, 1'b1);
    @(negedge clk);
    release_start();
    wait_done(nm);
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_busy"},   {31'h0, busy},   32'h0);
    chk({nm, "_done"},   {31'h0, done},   32'h0);
    chk({nm, "_result"}, {16'h0, result}, 32'h0);
    chk({nm, "_z"},      {31'h0, flag_z}, 32'h0);
    chk({nm, "_v"},      {31'h0, flag_v}, 32'h0);
    chk({nm, "_n"},      {31'h0, flag_n}, 32'h0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; sat_en = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Overflow, with and without saturation.
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, "add_sat");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_sat");

    // Zero result, inter-nibble carry, full wrap.
    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, "sub_zero");
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "carry");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");

    // Start while busy must be ignored.
    @(negedge clk);
    drive(16'h0010, 16'h0001, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    release_start();
    @(negedge clk);
    drive(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    release_start();
    wait_done("busy_ignore");
    repeat (6) @(negedge clk);

    // Back-to-back: next start presented during the DONE cycle.
    @(negedge clk);
    drive(16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    release_start();
    wait_done("b2b_first");
    drive(16'h5000, 16'h4000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    release_start();
    wait_done("b2b_second");

    // Reset in the third RUN cycle discards the op.
    run_op(16'h1234, 16'h0001, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    drive(16'h2222, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    release_start();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, "post_reset");

    // Randomised operations biased toward the signed boundaries.
    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), "random");
    end

    repeat (8) @(negedge clk);
    chk("queue_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
